// File: rtl/block_pingpong_reorder.sv
// block_pingpong_reorder: double-buffered BLK_DIM x BLK_DIM block buffer.
// Samples arrive in raster order. Each completed block is emitted in raster,
// transpose or zigzag order, selected by in_mode on the block's first sample.
// While one bank drains, the other bank fills.
// Optional build macro: BLKBUF_LEVEL_SHIFT_EN subtracts 2^(DATA_WIDTH-1) from
// every emitted sample (JPEG level shift). Handshake timing is the same with
// or without it.
module block_pingpong_reorder #(
  parameter int DATA_WIDTH = 8,
  parameter int BLK_DIM    = 8,
  parameter int IDX_W      = $clog2(BLK_DIM * BLK_DIM)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  busy
);

  localparam int DEPTH = BLK_DIM * BLK_DIM;
  // BLK_DIM is a power of two, so the row and column split the index evenly.
  localparam int LOG_DIM = IDX_W / 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1'b1);

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rd_state_e;

  // k-th raster address of the JPEG zigzag walk. Even anti-diagonals run
  // bottom-left to top-right, odd ones top-right to bottom-left.
  function automatic int zz_at(input int k);
    int n;
    int r;
    int c;
    int result;
    n      = 0;
    result = 0;
    for (int s = 0; s < 2 * BLK_DIM - 1; s++) begin
      for (int i = 0; i < BLK_DIM; i++) begin
        if (s % 2 == 0) begin
          r = ((s < BLK_DIM) ? s : BLK_DIM - 1) - i;
          c = s - r;
        end else begin
          c = ((s < BLK_DIM) ? s : BLK_DIM - 1) - i;
          r = s - c;
        end
        if (r >= 0 && c >= 0 && r < BLK_DIM && c < BLK_DIM) begin
          if (n == k) begin
            result = r * BLK_DIM + c;
          end
          n = n + 1;
        end
      end
    end
    return result;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [2][DEPTH];
  logic [1:0]            full_r;
  logic [1:0]            full_s;
  logic [1:0]            mode_r [2];
  logic                  wr_bank_r;
  logic [IDX_W-1:0]      wr_cnt_r;
  logic                  rd_bank_r;
  logic [IDX_W-1:0]      rd_cnt_r;
  rd_state_e             state_r;
  rd_state_e             state_s;

  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [IDX_W-1:0]      out_idx_r;
  logic                  out_last_r;

  logic                  in_ready_s;
  logic                  wr_fire_s;
  logic                  wr_last_s;
  logic                  rd_fire_s;
  logic                  rd_done_s;
  logic                  valid_s;
  logic                  load_s;
  logic                  load_bank_s;
  logic [IDX_W-1:0]      load_cnt_s;
  logic [1:0]            load_mode_s;
  logic [IDX_W-1:0]      load_addr_s;
  logic [DATA_WIDTH-1:0] load_raw_s;
  logic [DATA_WIDTH-1:0] load_data_s;
  logic [IDX_W-1:0]      zz_s [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_zz
    localparam int ZZ_ADDR = zz_at(k);
    assign zz_s[k] = ZZ_ADDR[IDX_W-1:0];
  end

  assign in_ready_s = ~full_r[wr_bank_r];
  assign wr_fire_s  = in_valid & in_ready_s;
  assign wr_last_s  = wr_fire_s & (wr_cnt_r == LAST_IDX);
  assign rd_fire_s  = out_valid_r & out_ready;

`ifdef BLKBUF_LEVEL_SHIFT_EN
  localparam logic [DATA_WIDTH-1:0] MSB_MASK = DATA_WIDTH'(1'b1) << (DATA_WIDTH - 1);
  // Flipping the MSB is the same as subtracting 2^(DATA_WIDTH-1) modulo 2^DATA_WIDTH.
  assign load_data_s = load_raw_s ^ MSB_MASK;
`else
  assign load_data_s = load_raw_s;
`endif

  // Sample storage: write-only on the fill side, no reset needed.
  always_ff @(posedge clock) begin
    if (wr_fire_s) begin
      mem_r[wr_bank_r][wr_cnt_r] <= in_data;
    end
  end

  // Full flags: set by the final write of a bank, cleared by its final read.
  always_comb begin
    full_s = full_r;
    for (int b = 0; b < 2; b++) begin
      full_s[b] = (wr_last_s && (wr_bank_r == 1'(b))) ||
                  (full_r[b] && !(rd_done_s && (rd_bank_r == 1'(b))));
    end
  end

  // Fill-side pointers, per-bank mode latch and full flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_r    <= 2'b00;
      mode_r[0] <= 2'd0;
      mode_r[1] <= 2'd0;
      wr_bank_r <= 1'b0;
      wr_cnt_r  <= ZERO_IDX;
    end else begin
      full_r <= full_s;
      if (wr_fire_s) begin
        if (wr_cnt_r == ZERO_IDX) begin
          mode_r[wr_bank_r] <= in_mode;
        end
        if (wr_cnt_r == LAST_IDX) begin
          wr_cnt_r  <= ZERO_IDX;
          wr_bank_r <= ~wr_bank_r;
        end else begin
          wr_cnt_r <= wr_cnt_r + ONE_IDX;
        end
      end
    end
  end

  // Drain FSM next state and prefetch decision for the output register.
  always_comb begin
    state_s     = state_r;
    valid_s     = out_valid_r;
    load_s      = 1'b0;
    load_bank_s = rd_bank_r;
    load_cnt_s  = rd_cnt_r;
    rd_done_s   = 1'b0;
    case (state_r)
      R_IDLE: begin
        state_s = full_r[rd_bank_r] ? R_DRAIN : R_IDLE;
      end
      R_DRAIN: begin
        if (!out_valid_r) begin
          // First sample of a freshly entered drain.
          load_s  = 1'b1;
          valid_s = 1'b1;
        end else if (rd_fire_s) begin
          if (rd_cnt_r == LAST_IDX) begin
            rd_done_s   = 1'b1;
            load_bank_s = ~rd_bank_r;
            load_cnt_s  = ZERO_IDX;
            if (full_r[~rd_bank_r]) begin
              // Other bank already waiting: continue without a bubble.
              load_s  = 1'b1;
              valid_s = 1'b1;
            end else begin
              valid_s = 1'b0;
              state_s = R_IDLE;
            end
          end else begin
            load_s     = 1'b1;
            load_cnt_s = rd_cnt_r + ONE_IDX;
          end
        end else begin
          load_s = 1'b0;
        end
      end
      default: begin
        state_s = R_IDLE;
      end
    endcase
  end

  // Read address map and bank read for the sample being prefetched.
  always_comb begin
    load_mode_s = mode_r[load_bank_s];
    case (load_mode_s)
      2'd1:    load_addr_s = {load_cnt_s[LOG_DIM-1:0], load_cnt_s[IDX_W-1:LOG_DIM]};
      2'd2:    load_addr_s = zz_s[load_cnt_s];
      default: load_addr_s = load_cnt_s;
    endcase
    load_raw_s = mem_r[load_bank_s][load_addr_s];
  end

  // Drain state, read pointers and registered output stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= R_IDLE;
      rd_bank_r   <= 1'b0;
      rd_cnt_r    <= ZERO_IDX;
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_idx_r   <= ZERO_IDX;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= valid_s;
      if (load_s) begin
        rd_bank_r  <= load_bank_s;
        rd_cnt_r   <= load_cnt_s;
        out_data_r <= load_data_s;
        out_idx_r  <= load_addr_s;
        out_last_r <= (load_cnt_s == LAST_IDX);
      end else if (rd_done_s) begin
        rd_bank_r <= ~rd_bank_r;
        rd_cnt_r  <= ZERO_IDX;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_idx   = out_idx_r;
  assign out_last  = out_last_r;
  assign busy      = full_r[0] | full_r[1] | (wr_cnt_r != ZERO_IDX);

endmodule

// File: tb/tb_block_pingpong_reorder.sv
// Self-checking bench for block_pingpong_reorder (DATA_WIDTH=8, BLK_DIM=8).
// Expected streams come from a block-level reference model: per completed
// block, the read order is derived from row/column arithmetic and a zigzag
// list built by grouping positions by anti-diagonal.
module tb_block_pingpong_reorder;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int D  = 64;
  localparam int IW = 6;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = 8'd0;
  logic [1:0]    in_mode = 2'd0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_count = 0;
  int last_in_cyc = 0;
  int first_valid_cyc = -1;

  logic [7:0] blk_data [8][64];
  logic [1:0] blk_mode [8];
  int         zz_tab [64];

  logic [7:0] exp_d [$];
  logic [5:0] exp_i [$];
  logic       exp_l [$];
  logic [7:0] obs_d [$];
  logic [5:0] obs_i [$];
  logic       obs_l [$];
  int         obs_c [$];

  block_pingpong_reorder #(.DATA_WIDTH(DW), .BLK_DIM(N)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog sim time limit reached, required finish before it");
    $fatal(1);
  end

  // Zigzag: visit anti-diagonals s=r+c in turn; odd diagonals in raster scan
  // order, even ones reversed.
  function automatic void init_zz();
    int n;
    int tmp [$];
    n = 0;
    for (int s = 0; s < 2 * N - 1; s++) begin
      tmp = {};
      for (int p = 0; p < D; p++) if (p / N + p % N == s) tmp.push_back(p);
      if (s % 2 == 0) tmp.reverse();
      foreach (tmp[j]) begin
        zz_tab[n] = tmp[j];
        n++;
      end
    end
  endfunction

  function automatic logic [7:0] exp_val(input logic [7:0] d);
`ifdef BLKBUF_LEVEL_SHIFT_EN
    return d - 8'd128;
`else
    return d;
`endif
  endfunction

  function automatic int model_addr(input logic [1:0] m, input int k);
    case (m)
      2'd1:    return (k % N) * N + k / N;
      2'd2:    return zz_tab[k];
      default: return k;
    endcase
  endfunction

  function automatic void expect_block(input int b);
    for (int k = 0; k < D; k++) begin
      int a;
      a = model_addr(blk_mode[b], k);
      exp_d.push_back(exp_val(blk_data[b][a]));
      exp_i.push_back(a[5:0]);
      exp_l.push_back(k == D - 1);
    end
  endfunction

  function automatic void fill_block(input int b, input logic [1:0] m, input bit rnd);
    blk_mode[b] = m;
    for (int k = 0; k < D; k++) blk_data[b][k] = rnd ? 8'($urandom_range(0, 255)) : 8'(k);
  endfunction

  function automatic void clear_q();
    exp_d = {}; exp_i = {}; exp_l = {};
    obs_d = {}; obs_i = {}; obs_l = {}; obs_c = {};
  endfunction

  // Feed n samples of block b; in_mode is random except on the first sample.
  task automatic push(input int b, input int n, input bit gaps, input int max_cyc);
    int k;
    int cycles;
    bit acc;
    k = 0;
    cycles = 0;
    while (k < n && cycles < max_cyc) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = blk_data[b][k];
      in_mode  = (k == 0) ? blk_mode[b] : 2'($urandom_range(0, 3));
      @(negedge clock);
      acc = in_valid && in_ready;
      @(posedge clock); #1;
      cycles++;
      if (acc) begin
        k++;
        acc_count++;
        last_in_cyc = cyc;
      end
    end
    in_valid = 1'b0;
    total++;
    if (k < n) begin
      bad++;
      $display("FAIL push_timeout block=%0d accepted=%0d required=%0d", b, k, n);
    end
  endtask

  // Accept n output samples; rmode 0 always ready, 1 toggling, 2 random.
  // Outputs held under backpressure must not change.
  task automatic collect(input int n, input int rmode, input int max_cyc);
    int got;
    int cycles;
    logic pv, pr, pl;
    logic [7:0] pd;
    logic [5:0] pi;
    got = 0;
    cycles = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'd0; pi = 6'd0;
    first_valid_cyc = -1;
    while (got < n && cycles < max_cyc) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cycles % 2 == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clock);
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (pv && !pr) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== pd || out_idx !== pi || out_last !== pl) begin
          bad++;
          $display("FAIL hold_stable valid=%0b data=%0h idx=%0d last=%0b required 1 %0h %0d %0b",
                   out_valid, out_data, out_idx, out_last, pd, pi, pl);
        end
      end
      if (out_valid && out_ready) begin
        obs_d.push_back(out_data);
        obs_i.push_back(out_idx);
        obs_l.push_back(out_last);
        obs_c.push_back(cyc);
        got++;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pi = out_idx; pl = out_last;
      @(posedge clock); #1;
      cycles++;
    end
    out_ready = 1'b0;
    total++;
    if (got < n) begin
      bad++;
      $display("FAIL collect_timeout got=%0d required=%0d", got, n);
    end
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    total += 6;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b required=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b required=0", out_valid); end
    if (out_data !== 8'd0) begin bad++; $display("FAIL reset_out_data got=%0h required=0", out_data); end
    if (out_idx !== 6'd0) begin bad++; $display("FAIL reset_out_idx got=%0d required=0", out_idx); end
    if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%0b required=0", out_last); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b required=0", busy); end
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_raster();
    clear_q();
    fill_block(0, 2'd0, 1'b0);
    expect_block(0);
    fork
      push(0, D, 1'b0, 500);
      collect(D, 0, 500);
    join
    for (int i = 0; i < exp_d.size(); i++) begin
      total++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_i[i] !== exp_i[i] || obs_l[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL raster_sample i=%0d got=%0h/%0d/%0b required=%0h/%0d/%0b",
                 i, obs_d[i], obs_i[i], obs_l[i], exp_d[i], exp_i[i], exp_l[i]);
      end
    end
    total++;
    if (first_valid_cyc - last_in_cyc !== 2) begin
      bad++;
      $display("FAIL raster_latency got=%0d required=2", first_valid_cyc - last_in_cyc);
    end
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL raster_idle_busy got=%0b required=0", busy); end
  endtask

  task automatic test_transpose();
    clear_q();
    fill_block(0, 2'd1, 1'b0);
    fill_block(1, 2'd1, 1'b1);
    expect_block(0);
    expect_block(1);
    fork
      begin push(0, D, 1'b0, 500); push(1, D, 1'b1, 1000); end
      collect(2 * D, 0, 1500);
    join
    for (int i = 0; i < exp_d.size(); i++) begin
      total++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_i[i] !== exp_i[i] || obs_l[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL transpose_sample i=%0d got=%0h/%0d/%0b required=%0h/%0d/%0b",
                 i, obs_d[i], obs_i[i], obs_l[i], exp_d[i], exp_i[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_zigzag();
    int jpeg_head [10] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
    clear_q();
    fill_block(0, 2'd2, 1'b0);
    expect_block(0);
    fork
      push(0, D, 1'b0, 500);
      collect(D, 0, 500);
    join
    for (int i = 0; i < exp_d.size(); i++) begin
      total++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_i[i] !== exp_i[i] || obs_l[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL zigzag_sample i=%0d got=%0h/%0d/%0b required=%0h/%0d/%0b",
                 i, obs_d[i], obs_i[i], obs_l[i], exp_d[i], exp_i[i], exp_l[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (obs_i[i] !== 6'(jpeg_head[i])) begin
        bad++;
        $display("FAIL zigzag_jpeg_table i=%0d got=%0d required=%0d", i, obs_i[i], jpeg_head[i]);
      end
    end
    total++;
    if (obs_i[D-2] !== 6'd62 || obs_i[D-1] !== 6'd63) begin
      bad++;
      $display("FAIL zigzag_tail got=%0d,%0d required=62,63", obs_i[D-2], obs_i[D-1]);
    end
  endtask

  task automatic test_pingpong_stall();
    clear_q();
    acc_count = 0;
    for (int b = 0; b < 3; b++) begin
      fill_block(b, 2'($urandom_range(0, 3)), 1'b1);
      expect_block(b);
    end
    out_ready = 1'b0;
    fork
      for (int b = 0; b < 3; b++) push(b, D, 1'b0, 3000);
      begin
        repeat (200) @(posedge clock);
        #1;
        total += 4;
        if (acc_count !== 2 * D) begin bad++; $display("FAIL stall_accepted got=%0d required=%0d", acc_count, 2 * D); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%0b required=0", in_ready); end
        if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid got=%0b required=1", out_valid); end
        if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%0b required=1", busy); end
        collect(3 * D, 0, 1500);
      end
    join
    for (int i = 0; i < exp_d.size(); i++) begin
      total++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_i[i] !== exp_i[i] || obs_l[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL stall_sample i=%0d got=%0h/%0d/%0b required=%0h/%0d/%0b",
                 i, obs_d[i], obs_i[i], obs_l[i], exp_d[i], exp_i[i], exp_l[i]);
      end
    end
    total++;
    if (obs_c[D] - obs_c[D-1] !== 1) begin
      bad++;
      $display("FAIL stall_no_bubble gap=%0d required=1", obs_c[D] - obs_c[D-1]);
    end
  endtask

  task automatic test_backpressure();
    clear_q();
    fill_block(0, 2'd2, 1'b1);
    expect_block(0);
    fork
      push(0, D, 1'b0, 500);
      collect(D, 1, 1000);
    join
    for (int i = 0; i < exp_d.size(); i++) begin
      total++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_i[i] !== exp_i[i] || obs_l[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL bp_sample i=%0d got=%0h/%0d/%0b required=%0h/%0d/%0b",
                 i, obs_d[i], obs_i[i], obs_l[i], exp_d[i], exp_i[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    clear_q();
    for (int b = 0; b < 5; b++) begin
      fill_block(b, 2'($urandom_range(0, 3)), 1'b1);
      expect_block(b);
    end
    fork
      for (int b = 0; b < 5; b++) push(b, D, 1'b1, 2000);
      collect(5 * D, 2, 5000);
    join
    for (int i = 0; i < exp_d.size(); i++) begin
      total++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_i[i] !== exp_i[i] || obs_l[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL random_sample i=%0d got=%0h/%0d/%0b required=%0h/%0d/%0b",
                 i, obs_d[i], obs_i[i], obs_l[i], exp_d[i], exp_i[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid_block();
    clear_q();
    fill_block(0, 2'd0, 1'b1);
    push(0, 30, 1'b0, 200);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL partial_busy got=%0b required=1", busy); end
    reset_n = 1'b0;
    #2;
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%0b required=0", busy); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got=%0b required=1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%0b required=0", out_valid); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    fill_block(1, 2'd0, 1'b1);
    blk_data[1][0] = 8'd0;
    expect_block(1);
    fork
      push(1, D, 1'b0, 500);
      collect(D, 0, 500);
    join
    for (int i = 0; i < exp_d.size(); i++) begin
      total++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_i[i] !== exp_i[i] || obs_l[i] !== exp_l[i]) begin
        bad++;
        $display("FAIL after_reset_sample i=%0d got=%0h/%0d/%0b required=%0h/%0d/%0b",
                 i, obs_d[i], obs_i[i], obs_l[i], exp_d[i], exp_i[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    init_zz();
    test_reset();
    test_raster();
    test_zigzag();
    test_transpose();
    test_pingpong_stall();
    test_backpressure();
    test_back_to_back_random();
    test_reset_mid_block();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
